// File: rtl/hpm_snapshot_ctrl.sv
// Snapshot sequencer for the hardware performance counters: freezes the selected counters,
// reads them out one at a time over the bank read port and streams them to a debug sink.
module hpm_snapshot_ctrl #(
  parameter int XLEN     = 64,
  parameter int COUNTERS = 32,
  parameter int INTW     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Enable,
  input  logic [INTW-1:0]     Interval,
  input  logic [COUNTERS-1:0] SampleMask,
  input  logic                SwTrigger,
  output logic [COUNTERS-1:0] FreezeMask,
  output logic                CntRdEn,
  output logic [4:0]          CntRdAdr,
  input  logic [XLEN-1:0]     CntRdData,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [4:0]          OutIdx,
  output logic [XLEN-1:0]     OutData,
  output logic                OutLast,
  output logic [7:0]          OutSeq,
  output logic                Busy,
  output logic                Overrun,
  output logic [15:0]         OverrunCount
);

  typedef enum logic [2:0] {IDLE, FREEZE, SCAN, SEND, RELEASE} state_e;

  state_e                state_q;
  logic [INTW-1:0]       intCnt_q, intCnt_d;
  logic [COUNTERS-1:0]   remain_q;
  logic [COUNTERS-1:0]   freezeMask_q;
  logic                  rdEn_q;
  logic [4:0]            rdAdr_q;
  logic                  outValid_q;
  logic [4:0]            outIdx_q;
  logic [XLEN-1:0]       outData_q;
  logic                  outLast_q;
  logic [7:0]            outSeq_q;
  logic                  overrun_q;
  logic [15:0]           overrunCnt_q;

  logic [INTW-1:0]       intervalM1;
  logic                  periodicHit;
  logic                  trigger;
  logic [COUNTERS-1:0]   effMask;
  logic [COUNTERS-1:0]   remainNext;

  function automatic logic [4:0] lowestIdx(input logic [COUNTERS-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = COUNTERS - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  // The >= compare lets a shortened Interval fire and wrap immediately instead of
  // letting the counter run all the way around.
  assign intervalM1  = Interval - 1'b1;
  assign periodicHit = Enable && (Interval != '0) && (intCnt_q >= intervalM1);
  assign trigger     = SwTrigger | periodicHit;
  assign effMask     = SampleMask & ~(COUNTERS'(2));
  assign remainNext  = remain_q & ~(COUNTERS'(1) << outIdx_q);

  always_comb begin
    intCnt_d = intCnt_q + 1'b1;
    if (!Enable || (Interval == '0) || (intCnt_q >= intervalM1)) intCnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      intCnt_q     <= '0;
      remain_q     <= '0;
      freezeMask_q <= '0;
      rdEn_q       <= 1'b0;
      rdAdr_q      <= '0;
      outValid_q   <= 1'b0;
      outIdx_q     <= '0;
      outData_q    <= '0;
      outLast_q    <= 1'b0;
      outSeq_q     <= '0;
      overrun_q    <= 1'b0;
      overrunCnt_q <= '0;
    end else begin
      intCnt_q  <= intCnt_d;
      overrun_q <= 1'b0;
      if (trigger && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
        if (overrunCnt_q != 16'hFFFF) overrunCnt_q <= overrunCnt_q + 16'd1;
      end
      case (state_q)
        IDLE: begin
          if (trigger && (effMask != '0)) begin
            remain_q     <= effMask;
            freezeMask_q <= effMask;
            state_q      <= FREEZE;
          end
        end
        FREEZE: begin
          rdEn_q  <= 1'b1;
          rdAdr_q <= lowestIdx(remain_q);
          state_q <= SCAN;
        end
        SCAN: begin
          rdEn_q     <= 1'b0;
          outData_q  <= CntRdData;
          outIdx_q   <= rdAdr_q;
          outLast_q  <= ((remain_q & (remain_q - 1'b1)) == '0);
          outValid_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          if (OutReady) begin
            outValid_q <= 1'b0;
            remain_q   <= remainNext;
            if (outLast_q) begin
              freezeMask_q <= '0;
              outSeq_q     <= outSeq_q + 8'd1;
              state_q      <= RELEASE;
            end else begin
              rdEn_q  <= 1'b1;
              rdAdr_q <= lowestIdx(remainNext);
              state_q <= SCAN;
            end
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign FreezeMask   = freezeMask_q;
  assign CntRdEn      = rdEn_q;
  assign CntRdAdr     = rdAdr_q;
  assign OutValid     = outValid_q;
  assign OutIdx       = outIdx_q;
  assign OutData      = outData_q;
  assign OutLast      = outLast_q;
  assign OutSeq       = outSeq_q;
  assign Busy         = (state_q != IDLE);
  assign Overrun      = overrun_q;
  assign OverrunCount = overrunCnt_q;

endmodule

// File: tb/tb_hpm_snapshot_ctrl.sv
// Bench for hpm_snapshot_ctrl: a free-running counter bank that honours FreezeMask, plus a
// scoreboard of expected snapshot words checked by a monitor on every accepted handshake.
module tb_hpm_snapshot_ctrl;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] data;
    logic        last;
  } word_t;

  logic        clk;
  logic        reset;
  logic        Enable;
  logic [31:0] Interval;
  logic [31:0] SampleMask;
  logic        SwTrigger;
  logic [31:0] FreezeMask;
  logic        CntRdEn;
  logic [4:0]  CntRdAdr;
  logic [63:0] CntRdData;
  logic        OutValid;
  logic        OutReady;
  logic [4:0]  OutIdx;
  logic [63:0] OutData;
  logic        OutLast;
  logic [7:0]  OutSeq;
  logic        Busy;
  logic        Overrun;
  logic [15:0] OverrunCount;

  logic [63:0] cnt [32];
  word_t       sbq[$];
  word_t       monWord;
  logic [7:0]  expSeq;
  int          vectors;
  int          miscompares;

  hpm_snapshot_ctrl dut (
    .clk(clk), .reset(reset), .Enable(Enable), .Interval(Interval),
    .SampleMask(SampleMask), .SwTrigger(SwTrigger), .FreezeMask(FreezeMask),
    .CntRdEn(CntRdEn), .CntRdAdr(CntRdAdr), .CntRdData(CntRdData),
    .OutValid(OutValid), .OutReady(OutReady), .OutIdx(OutIdx), .OutData(OutData),
    .OutLast(OutLast), .OutSeq(OutSeq), .Busy(Busy), .Overrun(Overrun),
    .OverrunCount(OverrunCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter bank model: every counter ticks each cycle unless its inhibit bit is set.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) cnt[i] <= (64'(i) << 24) | 64'hA5;
    end else begin
      for (int i = 0; i < 32; i++) if (!FreezeMask[i]) cnt[i] <= cnt[i] + 64'd1;
    end
  end

  assign CntRdData = cnt[CntRdAdr];

  always @(negedge clk) begin
    #1;
    if (!reset && OutValid && OutReady) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL word_unexpected: got idx=%0d data=%h, expected no word", OutIdx, OutData);
      end else begin
        monWord = sbq.pop_front();
        if (OutIdx !== monWord.idx || OutData !== monWord.data || OutLast !== monWord.last) begin
          miscompares++;
          $display("[TB] FAIL word: got idx=%0d data=%h last=%b, expected idx=%0d data=%h last=%b",
                   OutIdx, OutData, OutLast, monWord.idx, monWord.data, monWord.last);
        end
      end
    end
  end

  // Expected words for a snapshot, using the bank values as they stand once the freeze holds.
  task automatic pushSnapshot(input logic [31:0] m);
    int n;
    word_t w;
    n = 0;
    for (int i = 0; i < 32; i++) if (m[i] && i != 1) n++;
    for (int i = 0; i < 32; i++) begin
      if (m[i] && i != 1) begin
        n--;
        w.idx  = 5'(i);
        w.data = cnt[i];
        w.last = (n == 0);
        sbq.push_back(w);
      end
    end
  endtask

  task automatic waitIdle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!Busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    expSeq = 8'd0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({FreezeMask, CntRdEn, CntRdAdr, OutValid, OutIdx, OutData, OutLast, OutSeq,
         Busy, Overrun, OverrunCount} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got fm=%h valid=%b seq=%0d busy=%b ovc=%0d, expected all zero",
               FreezeMask, OutValid, OutSeq, Busy, OverrunCount);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    SampleMask = 32'h5; OutReady = 1'b1; SwTrigger = 1'b1;
    @(negedge clk);
    SwTrigger = 1'b0;
    pushSnapshot(32'h5);
    vectors++;
    if ({FreezeMask, Busy, OutValid} !== {32'h5, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL basic_freeze: got fm=%h busy=%b valid=%b, expected fm=5 busy=1 valid=0", FreezeMask, Busy, OutValid);
    end
    @(negedge clk);
    vectors++;
    if ({CntRdEn, CntRdAdr, FreezeMask, OutValid} !== {1'b1, 5'd0, 32'h5, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL basic_scan0: got en=%b adr=%0d fm=%h valid=%b, expected en=1 adr=0 fm=5 valid=0", CntRdEn, CntRdAdr, FreezeMask, OutValid);
    end
    @(negedge clk);
    vectors++;
    if ({OutValid, OutIdx, OutLast, FreezeMask} !== {1'b1, 5'd0, 1'b0, 32'h5}) begin
      miscompares++;
      $display("[TB] FAIL basic_word0: got valid=%b idx=%0d last=%b fm=%h, expected valid=1 idx=0 last=0 fm=5", OutValid, OutIdx, OutLast, FreezeMask);
    end
    @(negedge clk);
    vectors++;
    if ({OutValid, CntRdEn, CntRdAdr} !== {1'b0, 1'b1, 5'd2}) begin
      miscompares++;
      $display("[TB] FAIL basic_scan2: got valid=%b en=%b adr=%0d, expected valid=0 en=1 adr=2", OutValid, CntRdEn, CntRdAdr);
    end
    @(negedge clk);
    vectors++;
    if ({OutValid, OutIdx, OutLast, FreezeMask} !== {1'b1, 5'd2, 1'b1, 32'h5}) begin
      miscompares++;
      $display("[TB] FAIL basic_word2: got valid=%b idx=%0d last=%b fm=%h, expected valid=1 idx=2 last=1 fm=5", OutValid, OutIdx, OutLast, FreezeMask);
    end
    @(negedge clk);
    expSeq++;
    vectors++;
    if ({FreezeMask, OutValid, OutSeq} !== {32'h0, 1'b0, expSeq}) begin
      miscompares++;
      $display("[TB] FAIL basic_release: got fm=%h valid=%b seq=%0d, expected fm=0 valid=0 seq=%0d", FreezeMask, OutValid, OutSeq, expSeq);
    end
    @(negedge clk);
    vectors++;
    if (Busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_idle: got busy=%b, expected 0", Busy);
    end
  endtask

  task automatic test_stall();
    bit ok;
    @(negedge clk);
    SampleMask = 32'h5; OutReady = 1'b0; SwTrigger = 1'b1;
    @(negedge clk);
    SwTrigger = 1'b0;
    pushSnapshot(32'h5);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({OutValid, OutIdx, OutData, FreezeMask} !== {1'b1, sbq[0].idx, sbq[0].data, 32'h5}) begin
        miscompares++;
        $display("[TB] FAIL stall_hold: got valid=%b idx=%0d data=%h fm=%h, expected valid=1 idx=%0d data=%h fm=5",
                 OutValid, OutIdx, OutData, FreezeMask, sbq[0].idx, sbq[0].data);
      end
      @(negedge clk);
    end
    OutReady = 1'b1;
    waitIdle(ok);
    expSeq++;
    vectors++;
    if (!ok || OutSeq !== expSeq) begin
      miscompares++;
      $display("[TB] FAIL stall_done: got idle=%b seq=%0d, expected idle=1 seq=%0d", ok, OutSeq, expSeq);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    @(negedge clk);
    SampleMask = 32'h1; OutReady = 1'b0; SwTrigger = 1'b1;
    @(negedge clk);
    SwTrigger = 1'b0;
    pushSnapshot(32'h1);
    @(negedge clk);
    @(negedge clk);
    SwTrigger = 1'b1;
    @(negedge clk);
    SwTrigger = 1'b0;
    vectors++;
    if ({Overrun, OverrunCount} !== {1'b1, 16'd1}) begin
      miscompares++;
      $display("[TB] FAIL overrun_pulse: got ovr=%b cnt=%0d, expected ovr=1 cnt=1", Overrun, OverrunCount);
    end
    @(negedge clk);
    vectors++;
    if ({Overrun, OverrunCount} !== {1'b0, 16'd1}) begin
      miscompares++;
      $display("[TB] FAIL overrun_one_cycle: got ovr=%b cnt=%0d, expected ovr=0 cnt=1", Overrun, OverrunCount);
    end
    SwTrigger = 1'b1;
    repeat (100) @(negedge clk);
    vectors++;
    if (OverrunCount !== 16'd101) begin
      miscompares++;
      $display("[TB] FAIL overrun_count: got %0d, expected 101", OverrunCount);
    end
    repeat (69900) @(negedge clk);
    SwTrigger = 1'b0;
    @(negedge clk);
    vectors++;
    if (OverrunCount !== 16'hFFFF) begin
      miscompares++;
      $display("[TB] FAIL overrun_saturate: got %h, expected ffff", OverrunCount);
    end
    OutReady = 1'b1;
    waitIdle(ok);
    expSeq++;
    vectors++;
    if (!ok || OutSeq !== expSeq) begin
      miscompares++;
      $display("[TB] FAIL overrun_done: got idle=%b seq=%0d, expected idle=1 seq=%0d", ok, OutSeq, expSeq);
    end
  endtask

  task automatic test_ignore();
    logic [31:0] masks [2];
    masks[0] = 32'h2;
    masks[1] = 32'h0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      SampleMask = masks[k]; SwTrigger = 1'b1;
      @(negedge clk);
      SwTrigger = 1'b0;
      vectors++;
      if ({Busy, FreezeMask, Overrun} !== '0) begin
        miscompares++;
        $display("[TB] FAIL ignore_mask_%0h: got busy=%b fm=%h ovr=%b, expected all zero", masks[k], Busy, FreezeMask, Overrun);
      end
    end
  endtask

  task automatic test_periodic();
    int trig[$];
    int expTrig [4];
    logic [31:0] prevFm;
    bit ok;
    expTrig[0] = 99; expTrig[1] = 150; expTrig[2] = 160; expTrig[3] = 170;
    doReset();
    @(negedge clk);
    SampleMask = 32'h1; OutReady = 1'b1; Interval = 32'd100; Enable = 1'b1;
    prevFm = '0;
    for (int n = 1; n <= 175; n++) begin
      @(negedge clk);
      if (FreezeMask != '0 && prevFm == '0) begin
        trig.push_back(n - 1);
        pushSnapshot(32'h1);
      end
      prevFm = FreezeMask;
      if (n == 150) Interval = 32'd10;
    end
    Enable = 1'b0;
    waitIdle(ok);
    vectors++;
    if (!ok || trig.size() != 4) begin
      miscompares++;
      $display("[TB] FAIL periodic_count: got %0d triggers idle=%b, expected 4 idle=1", trig.size(), ok);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (trig[i] != expTrig[i]) begin
          miscompares++;
          $display("[TB] FAIL periodic_time_%0d: got cycle %0d, expected cycle %0d", i, trig[i], expTrig[i]);
        end
      end
    end
    expSeq += 8'd4;
    vectors++;
    if (OutSeq !== expSeq) begin
      miscompares++;
      $display("[TB] FAIL periodic_seq: got %0d, expected %0d", OutSeq, expSeq);
    end
  endtask

  task automatic test_coincident();
    bit ok;
    doReset();
    @(negedge clk);
    SampleMask = 32'h1; OutReady = 1'b1; Interval = 32'd5; Enable = 1'b1;
    repeat (4) @(negedge clk);
    SwTrigger = 1'b1;
    @(negedge clk);
    SwTrigger = 1'b0; Enable = 1'b0;
    pushSnapshot(32'h1);
    vectors++;
    if ({FreezeMask, Overrun} !== {32'h1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL coincident_start: got fm=%h ovr=%b, expected fm=1 ovr=0", FreezeMask, Overrun);
    end
    @(negedge clk);
    vectors++;
    if ({Overrun, OverrunCount} !== {1'b0, 16'd0}) begin
      miscompares++;
      $display("[TB] FAIL coincident_overrun: got ovr=%b cnt=%0d, expected ovr=0 cnt=0", Overrun, OverrunCount);
    end
    waitIdle(ok);
    expSeq++;
    vectors++;
    if (!ok || OutSeq !== expSeq) begin
      miscompares++;
      $display("[TB] FAIL coincident_seq: got idle=%b seq=%0d, expected idle=1 seq=%0d", ok, OutSeq, expSeq);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(negedge clk);
    SampleMask = 32'h5; OutReady = 1'b0; SwTrigger = 1'b1;
    @(negedge clk);
    SwTrigger = 1'b0;
    pushSnapshot(32'h5);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (OutValid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_pre: got valid=%b, expected 1", OutValid);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({OutValid, FreezeMask, Busy} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_async: got valid=%b fm=%h busy=%b, expected all zero", OutValid, FreezeMask, Busy);
    end
    sbq.delete();
    expSeq = 8'd0;
    @(negedge clk);
    reset = 1'b0;
    OutReady = 1'b1; SwTrigger = 1'b1;
    @(negedge clk);
    SwTrigger = 1'b0;
    pushSnapshot(32'h5);
    waitIdle(ok);
    expSeq++;
    vectors++;
    if (!ok || OutSeq !== expSeq) begin
      miscompares++;
      $display("[TB] FAIL midreset_restart: got idle=%b seq=%0d, expected idle=1 seq=%0d", ok, OutSeq, expSeq);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; expSeq = 8'd0;
    reset = 1'b1; Enable = 1'b0; Interval = '0; SampleMask = '0;
    SwTrigger = 1'b0; OutReady = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_ignore();
    test_overrun();
    test_periodic();
    test_coincident();
    test_reset_mid();
    repeat (3) @(negedge clk);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d words outstanding, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
